fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
Instruction-fetch stage of the 16-bit CPU. Owns the program counter and drives the byte address into the instruction memory, which returns a combinational 16-bit little-endian instruction word. Latches each fetched word with its PC into the IF/ID pipeline register. Handles hazard stalls, branch/jump redirects (flush) and HALT detection.

Parameters:
ADDR_W, 16, PC / instruction-address width
RESET_PC, 16'h0000, PC value loaded on reset
HALT_INSTR, 16'hF000, encoding that stops fetch
NOP_INSTR, 16'h0000, value written to ifid_instr when a bubble is inserted

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, synchronous, active-high
imem_addr  out  ADDR_W  byte address to instruction memory; equals pc combinationally
imem_data  in  16  instruction word from memory at imem_addr, same cycle
stall  in  1  hazard unit request: hold PC and IF/ID
redirect  in  1  taken branch/jump from a later stage
redirect_pc  in  ADDR_W  redirect target; bit 0 ignored (forced 0)
ifid_instr  out  16  IF/ID instruction
ifid_pc  out  ADDR_W  IF/ID address of the instruction
ifid_pc_plus2  out  ADDR_W  IF/ID pc+2 (link/branch base)
ifid_valid  out  1  IF/ID holds a real instruction
halted  out  1  fetch stopped on HALT

Behaviour:
- Reset (rst=1 at the edge, overrides all other inputs, including mid-operation): pc=RESET_PC, ifid_instr=NOP_INSTR, ifid_pc=0, ifid_pc_plus2=0, ifid_valid=0, halted=0, state=RUN.
- Latency: the word at pc appears in IF/ID on the next edge. The first valid IF/ID occurs one cycle after rst deasserts.
- State RUN, priority at each edge:
  1. redirect=1: pc<={redirect_pc[15:1],1'b0}; IF/ID flushed (valid=0, instr=NOP_INSTR). stall is ignored and imem_data is discarded, even if it is HALT.
  2. stall=1: pc and all IF/ID outputs hold. HALT on imem_data is not acted on.
  3. imem_data==HALT_INSTR: IF/ID <= {HALT_INSTR, pc, pc+2, valid=1}; pc holds; state->HALTED; halted=1 from this edge.
  4. Otherwise: IF/ID <= {imem_data, pc, pc+2, valid=1}; pc<=pc+2.
- State HALTED:
  - redirect=1: same as RUN rule 1, then state->RUN and halted=0. This covers a HALT fetched under a shadowing branch.
  - stall=1: IF/ID holds, so the HALT word stays visible downstream.
  - Otherwise: ifid_valid<=0 and ifid_instr<=NOP_INSTR. HALT is delivered downstream exactly once. pc holds.
  - Only redirect or rst leaves HALTED.
- Arithmetic: pc+2 is modulo 2^ADDR_W (16'hFFFE -> 16'h0000). pc is always even.
- No combinational path from stall or redirect to imem_addr. imem_addr is a pure function of the pc register.

Decomposition:
- Shared package cpu_pkg: ADDR_W, INSTR_W=16, HALT_INSTR, NOP_INSTR, and the fetch state enum {RUN, HALTED}.
- One sub-module, fetch_next_pc: combinational next-PC select (reset / redirect / hold / +2). Keeps the pc update testable in isolation.
- IF/ID register and FSM live in fetch_stage.

Test Plan:
1. Reset, then free run with memory returning 16'h0E20@0 and 16'h0B21@2 -> edge 1: ifid_instr=0E20, ifid_pc=0, ifid_pc_plus2=2, valid=1. Edge 2: ifid_instr=0B21, ifid_pc=2, imem_addr=4.
2. stall=1 for 2 cycles with pc=4 -> imem_addr stays 4 and IF/ID unchanged. On release, the word @4 is latched with ifid_pc=4.
3. redirect=1, redirect_pc=16'h0013, stall=1 simultaneously -> next edge: imem_addr=0012, ifid_valid=0, ifid_instr=0000. Following edge: ifid_pc=0012, valid=1.
4. Memory returns F000 @003E -> edge: ifid_instr=F000, ifid_pc=003E, valid=1, halted=1. Next edge: valid=0. imem_addr stays 003E and halted stays 1 for 10+ cycles.
5. HALTED, then redirect=1, redirect_pc=0014 -> halted=0, ifid_valid=0, imem_addr=0014. Next edge: the instruction @0014 is latched with valid=1.
6. rst=1 mid-run at pc=0020 while redirect=1 -> next edge: imem_addr=0000, ifid_valid=0, halted=0, all IF/ID fields at their reset values.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: widths, special instruction encodings, fetch FSM states.
package cpu_pkg;

  localparam int unsigned ADDR_W     = 16;
  localparam int unsigned INSTR_W    = 16;
  localparam logic [15:0] RESET_PC   = 16'h0000;
  localparam logic [15:0] HALT_INSTR = 16'hF000;
  localparam logic [15:0] NOP_INSTR  = 16'h0000;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_next_pc.sv
// Next-PC select for the fetch stage: reset, redirect, sequential advance or hold.
module fetch_next_pc #(
  parameter int unsigned          ADDR_W   = 16,
  parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
  input  logic              rst_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  input  logic              advance_i,
  input  logic [ADDR_W-1:0] pc_i,
  output logic [ADDR_W-1:0] pc_d_o
);

  // Priority select; redirect targets are forced even, +2 wraps modulo 2^ADDR_W.
  always_comb begin
    pc_d_o = pc_i;
    if (rst_i) begin
      pc_d_o = RESET_PC;
    end else if (redirect_i) begin
      pc_d_o = redirect_pc_i & ~ADDR_W'(1);
    end else if (advance_i) begin
      pc_d_o = pc_i + ADDR_W'(2);
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives instruction memory, fills the
// IF/ID register, and handles stall, redirect/flush and HALT detection.
module fetch_stage #(
  parameter int unsigned       ADDR_W     = cpu_pkg::ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC   = cpu_pkg::RESET_PC,
  parameter logic [15:0]       HALT_INSTR = cpu_pkg::HALT_INSTR,
  parameter logic [15:0]       NOP_INSTR  = cpu_pkg::NOP_INSTR
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [15:0]       imem_data,
  input  logic              stall,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [15:0]       ifid_instr,
  output logic [ADDR_W-1:0] ifid_pc,
  output logic [ADDR_W-1:0] ifid_pc_plus2,
  output logic              ifid_valid,
  output logic              halted
);

  import cpu_pkg::*;

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [15:0]       instr_q, instr_d;
  logic [ADDR_W-1:0] ifpc_q, ifpc_d;
  logic [ADDR_W-1:0] ifpc2_q, ifpc2_d;
  logic              valid_q, valid_d;
  logic              advance;

  fetch_next_pc #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_next_pc (
    .rst_i         (rst),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .advance_i     (advance),
    .pc_i          (pc_q),
    .pc_d_o        (pc_d)
  );

  // Fetch FSM next state and IF/ID next values; redirect > stall > HALT > normal.
  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    ifpc_d  = ifpc_q;
    ifpc2_d = ifpc2_q;
    valid_d = valid_q;
    advance = 1'b0;
    unique case (state_q)
      RUN: begin
        if (redirect) begin
          instr_d = NOP_INSTR;
          valid_d = 1'b0;
        end else if (!stall) begin
          instr_d = imem_data;
          ifpc_d  = pc_q;
          ifpc2_d = pc_q + ADDR_W'(2);
          valid_d = 1'b1;
          if (imem_data == HALT_INSTR) begin
            state_d = HALTED;
          end else begin
            advance = 1'b1;
          end
        end
      end
      HALTED: begin
        if (redirect) begin
          instr_d = NOP_INSTR;
          valid_d = 1'b0;
          state_d = RUN;
        end else if (!stall) begin
          // HALT was delivered on the previous edge; bubble from now on.
          instr_d = NOP_INSTR;
          valid_d = 1'b0;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // State, PC and IF/ID registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      ifpc_q  <= '0;
      ifpc2_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      ifpc_q  <= ifpc_d;
      ifpc2_q <= ifpc2_d;
      valid_q <= valid_d;
    end
  end

  assign imem_addr     = pc_q;
  assign ifid_instr    = instr_q;
  assign ifid_pc       = ifpc_q;
  assign ifid_pc_plus2 = ifpc2_q;
  assign ifid_valid    = valid_q;
  assign halted        = (state_q == HALTED);

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized
// traffic against a behavioural model of the fetch rules.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] imem_addr;
  logic [15:0] imem_data;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic [15:0] ifid_instr;
  logic [15:0] ifid_pc;
  logic [15:0] ifid_pc_plus2;
  logic        ifid_valid;
  logic        halted;

  int unsigned pass_cnt = 0;
  int unsigned total_cnt = 0;

  logic [15:0] mem [0:32767];

  // Reference model state.
  logic [15:0] m_pc, m_instr, m_ifpc, m_ifpc2;
  logic        m_valid, m_halted;

  always #5 clk = ~clk;

  assign imem_data = mem[imem_addr[15:1]];

  fetch_stage #(
    .ADDR_W     (16),
    .RESET_PC   (16'h0000),
    .HALT_INSTR (16'hF000),
    .NOP_INSTR  (16'h0000)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_addr     (imem_addr),
    .imem_data     (imem_data),
    .stall         (stall),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .ifid_instr    (ifid_instr),
    .ifid_pc       (ifid_pc),
    .ifid_pc_plus2 (ifid_pc_plus2),
    .ifid_valid    (ifid_valid),
    .halted        (halted)
  );

  // One clock: drive inputs, advance the model by the fetch rules, sample after the edge.
  task automatic step(input logic r, input logic s, input logic rd, input logic [15:0] rpc);
    logic [15:0] w;
    rst = r; stall = s; redirect = rd; redirect_pc = rpc;
    w = mem[m_pc / 2];
    @(posedge clk);
    if (r) begin
      m_pc = 16'h0000; m_instr = 16'h0000; m_ifpc = 16'h0000; m_ifpc2 = 16'h0000;
      m_valid = 1'b0; m_halted = 1'b0;
    end else if (rd) begin
      m_pc = rpc - (rpc % 2);
      m_instr = 16'h0000; m_valid = 1'b0; m_halted = 1'b0;
    end else if (s) begin
      // everything holds
    end else if (m_halted) begin
      m_instr = 16'h0000; m_valid = 1'b0;
    end else begin
      m_instr = w; m_ifpc = m_pc; m_ifpc2 = 16'((32'(m_pc) + 2) % 65536); m_valid = 1'b1;
      if (w == 16'hF000) m_halted = 1'b1;
      else m_pc = 16'((32'(m_pc) + 2) % 65536);
    end
    #1;
  endtask

  task automatic test_reset();
    step(1'b1, 1'b0, 1'b0, 16'h0000);
    step(1'b1, 1'b1, 1'b1, 16'h0044);
    total_cnt++;
    if ({imem_addr, ifid_instr, ifid_pc, ifid_pc_plus2, ifid_valid, halted} !== {16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0})
      $display("FAIL reset: addr=%h instr=%h pc=%h pc2=%h valid=%b halted=%b, required all zero",
               imem_addr, ifid_instr, ifid_pc, ifid_pc_plus2, ifid_valid, halted);
    else pass_cnt++;
  endtask

  task automatic test_free_run();
    step(1'b0, 1'b0, 1'b0, 16'h0000);
    total_cnt++;
    if ({ifid_instr, ifid_pc, ifid_pc_plus2, ifid_valid, imem_addr} !== {16'h0E20, 16'h0000, 16'h0002, 1'b1, 16'h0002})
      $display("FAIL free_run_edge1: instr=%h pc=%h pc2=%h valid=%b addr=%h, required 0e20 0000 0002 1 0002",
               ifid_instr, ifid_pc, ifid_pc_plus2, ifid_valid, imem_addr);
    else pass_cnt++;
    step(1'b0, 1'b0, 1'b0, 16'h0000);
    total_cnt++;
    if ({ifid_instr, ifid_pc, ifid_pc_plus2, imem_addr} !== {16'h0B21, 16'h0002, 16'h0004, 16'h0004})
      $display("FAIL free_run_edge2: instr=%h pc=%h pc2=%h addr=%h, required 0b21 0002 0004 0004",
               ifid_instr, ifid_pc, ifid_pc_plus2, imem_addr);
    else pass_cnt++;
  endtask

  task automatic test_stall();
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b1, 1'b0, 16'h0000);
      total_cnt++;
      if ({imem_addr, ifid_instr, ifid_pc, ifid_valid} !== {16'h0004, 16'h0B21, 16'h0002, 1'b1})
        $display("FAIL stall_hold%0d: addr=%h instr=%h pc=%h valid=%b, required 0004 0b21 0002 1",
                 i, imem_addr, ifid_instr, ifid_pc, ifid_valid);
      else pass_cnt++;
    end
    step(1'b0, 1'b0, 1'b0, 16'h0000);
    total_cnt++;
    if ({ifid_instr, ifid_pc, imem_addr} !== {mem[2], 16'h0004, 16'h0006})
      $display("FAIL stall_release: instr=%h pc=%h addr=%h, required %h 0004 0006",
               ifid_instr, ifid_pc, imem_addr, mem[2]);
    else pass_cnt++;
  endtask

  task automatic test_redirect_stall();
    step(1'b0, 1'b1, 1'b1, 16'h0013);
    total_cnt++;
    if ({imem_addr, ifid_valid, ifid_instr} !== {16'h0012, 1'b0, 16'h0000})
      $display("FAIL redirect_flush: addr=%h valid=%b instr=%h, required 0012 0 0000",
               imem_addr, ifid_valid, ifid_instr);
    else pass_cnt++;
    step(1'b0, 1'b0, 1'b0, 16'h0000);
    total_cnt++;
    if ({ifid_pc, ifid_valid, ifid_instr} !== {16'h0012, 1'b1, mem[9]})
      $display("FAIL redirect_target: pc=%h valid=%b instr=%h, required 0012 1 %h",
               ifid_pc, ifid_valid, ifid_instr, mem[9]);
    else pass_cnt++;
  endtask

  task automatic test_halt();
    int unsigned bad;
    step(1'b0, 1'b0, 1'b1, 16'h003E);
    step(1'b0, 1'b0, 1'b0, 16'h0000);
    total_cnt++;
    if ({ifid_instr, ifid_pc, ifid_valid, halted, imem_addr} !== {16'hF000, 16'h003E, 1'b1, 1'b1, 16'h003E})
      $display("FAIL halt_latch: instr=%h pc=%h valid=%b halted=%b addr=%h, required f000 003e 1 1 003e",
               ifid_instr, ifid_pc, ifid_valid, halted, imem_addr);
    else pass_cnt++;
    step(1'b0, 1'b1, 1'b0, 16'h0000);
    total_cnt++;
    if ({ifid_instr, ifid_valid, halted} !== {16'hF000, 1'b1, 1'b1})
      $display("FAIL halt_stall_hold: instr=%h valid=%b halted=%b, required f000 1 1",
               ifid_instr, ifid_valid, halted);
    else pass_cnt++;
    step(1'b0, 1'b0, 1'b0, 16'h0000);
    total_cnt++;
    if ({ifid_instr, ifid_valid, halted} !== {16'h0000, 1'b0, 1'b1})
      $display("FAIL halt_once: instr=%h valid=%b halted=%b, required 0000 0 1",
               ifid_instr, ifid_valid, halted);
    else pass_cnt++;
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'($urandom_range(0, 1)), 1'b0, 16'h0000);
      if (imem_addr !== 16'h003E || halted !== 1'b1 || ifid_valid !== 1'b0) bad++;
    end
    total_cnt++;
    if (bad != 0)
      $display("FAIL halt_sticky: %0d bad cycles, last addr=%h halted=%b valid=%b, required 003e 1 0",
               bad, imem_addr, halted, ifid_valid);
    else pass_cnt++;
  endtask

  task automatic test_halt_redirect();
    step(1'b0, 1'b0, 1'b1, 16'h0014);
    total_cnt++;
    if ({halted, ifid_valid, imem_addr} !== {1'b0, 1'b0, 16'h0014})
      $display("FAIL halt_exit: halted=%b valid=%b addr=%h, required 0 0 0014", halted, ifid_valid, imem_addr);
    else pass_cnt++;
    step(1'b0, 1'b0, 1'b0, 16'h0000);
    total_cnt++;
    if ({ifid_pc, ifid_valid, ifid_instr} !== {16'h0014, 1'b1, mem[10]})
      $display("FAIL halt_exit_fetch: pc=%h valid=%b instr=%h, required 0014 1 %h",
               ifid_pc, ifid_valid, ifid_instr, mem[10]);
    else pass_cnt++;
  endtask

  task automatic test_wrap();
    step(1'b0, 1'b0, 1'b1, 16'hFFFF);
    step(1'b0, 1'b0, 1'b0, 16'h0000);
    total_cnt++;
    if ({ifid_pc, ifid_pc_plus2, imem_addr, ifid_instr} !== {16'hFFFE, 16'h0000, 16'h0000, mem[32767]})
      $display("FAIL pc_wrap: pc=%h pc2=%h addr=%h instr=%h, required fffe 0000 0000 %h",
               ifid_pc, ifid_pc_plus2, imem_addr, ifid_instr, mem[32767]);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    step(1'b0, 1'b0, 1'b1, 16'h0020);
    step(1'b1, 1'b0, 1'b1, 16'h0056);
    total_cnt++;
    if ({imem_addr, ifid_instr, ifid_pc, ifid_pc_plus2, ifid_valid, halted} !== {16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0})
      $display("FAIL reset_mid: addr=%h instr=%h pc=%h pc2=%h valid=%b halted=%b, required all zero",
               imem_addr, ifid_instr, ifid_pc, ifid_pc_plus2, ifid_valid, halted);
    else pass_cnt++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 7) == 0), 16'($urandom_range(0, 255)));
      total_cnt++;
      if ({imem_addr, ifid_instr, ifid_pc, ifid_pc_plus2, ifid_valid, halted} !==
          {m_pc, m_instr, m_ifpc, m_ifpc2, m_valid, m_halted})
        $display("FAIL random[%0d]: got addr=%h instr=%h pc=%h pc2=%h v=%b h=%b, required %h %h %h %h %b %b",
                 i, imem_addr, ifid_instr, ifid_pc, ifid_pc_plus2, ifid_valid, halted,
                 m_pc, m_instr, m_ifpc, m_ifpc2, m_valid, m_halted);
      else pass_cnt++;
    end
  endtask

  initial begin
    m_pc = '0; m_instr = '0; m_ifpc = '0; m_ifpc2 = '0; m_valid = 1'b0; m_halted = 1'b0;
    for (int i = 0; i < 32768; i++) begin
      mem[i] = 16'($urandom);
      if (mem[i] == 16'hF000) mem[i] = 16'h1234;
    end
    for (int i = 64; i < 128; i++)
      if ($urandom_range(0, 5) == 0) mem[i] = 16'hF000;
    mem[0]  = 16'h0E20;
    mem[1]  = 16'h0B21;
    mem[31] = 16'hF000;

    test_reset();
    test_free_run();
    test_stall();
    test_redirect_stall();
    test_halt();
    test_halt_redirect();
    test_wrap();
    test_reset_mid();
    test_random();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
